// File: rtl/dcache_pkg.sv
// Shared encodings and the byte-lane helper for the set-associative data cache.
package dcache_pkg;

  localparam logic [1:0] WE_IDLE  = 2'b00;
  localparam logic [1:0] WE_READ  = 2'b01;
  localparam logic [1:0] WE_WRITE = 2'b10;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_BYTE = 2'b01;
  localparam logic [1:0] DT_HALF = 2'b10;

  typedef enum logic {IDLE, REFILL} state_t;

  // dataType 11 falls into the word case.
  function automatic logic [3:0] lane_strb(input logic [1:0] dt, input logic [1:0] off);
    case (dt)
      DT_BYTE: return 4'b0001 << off;
      DT_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: per-set valid bit and tag plus a block of data words per set.
module dcache_way #(
  parameter int SET_BITS = 4,
  parameter int OFF_W    = 2,
  parameter int TAG_W    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] rd_set,
  input  logic [OFF_W-1:0]    rd_word,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [31:0]         rd_data,
  input  logic                wr_en,
  input  logic [SET_BITS-1:0] wr_set,
  input  logic [OFF_W-1:0]    wr_word,
  input  logic [31:0]         wr_data,
  input  logic [3:0]          wr_strb,
  input  logic                clr_valid,
  input  logic                set_valid,
  input  logic [TAG_W-1:0]    tag_in
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << OFF_W;

  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][WORDS];

  assign rd_valid = valid_q[rd_set];
  assign rd_tag   = tag_q[rd_set];
  assign rd_data  = data_q[rd_set][rd_word];

  // Clear targets the lookup set, set-valid targets the set being refilled.
  always_comb begin
    valid_d = valid_q;
    if (clr_valid) valid_d[rd_set] = 1'b0;
    if (set_valid) valid_d[wr_set] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (set_valid) tag_q[wr_set] <= tag_in;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) data_q[wr_set][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-through data cache with a synchronous block-refill FSM
// and a valid/ready memory port with in-order read responses.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int SET_BITS    = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int WAYS        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            WE,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [1:0]            dataType,
  input  logic [31:0]           WD,
  output logic [31:0]           RD,
  output logic                  stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int TAG_W = ADDR_WIDTH - SET_BITS - OFF_W - 2;
  localparam int SETS  = 1 << SET_BITS;
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

  logic [OFF_W-1:0]    a_word;
  logic [SET_BITS-1:0] a_set;
  logic [TAG_W-1:0]    a_tag;
  assign a_word = A[2 +: OFF_W];
  assign a_set  = A[2 + OFF_W +: SET_BITS];
  assign a_tag  = A[ADDR_WIDTH-1 -: TAG_W];

  state_t              state_q, state_d;
  logic [SET_BITS-1:0] fill_set_q, fill_set_d;
  logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
  logic                fill_way_q, fill_way_d;
  logic [CNT_W-1:0]    req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]    rsp_cnt_q, rsp_cnt_d;
  logic [SETS-1:0]     lru_q, lru_d;

  logic [WAYS-1:0]     way_valid, way_hit, way_wr, way_clr, way_set;
  logic [TAG_W-1:0]    way_tag  [WAYS];
  logic [31:0]         way_data [WAYS];
  logic [SET_BITS-1:0] wr_set;
  logic [OFF_W-1:0]    wr_word;
  logic [31:0]         wr_data, hit_data, lane_data;
  logic [3:0]          wr_strb;
  logic                hit, hit_way, victim;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way #(.SET_BITS(SET_BITS), .OFF_W(OFF_W), .TAG_W(TAG_W)) u_way (
      .clk(clk), .rst(rst),
      .rd_set(a_set), .rd_word(a_word),
      .rd_valid(way_valid[w]), .rd_tag(way_tag[w]), .rd_data(way_data[w]),
      .wr_en(way_wr[w]), .wr_set(wr_set), .wr_word(wr_word),
      .wr_data(wr_data), .wr_strb(wr_strb),
      .clr_valid(way_clr[w]), .set_valid(way_set[w]), .tag_in(fill_tag_q)
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == a_tag);
  end

  assign hit = |way_hit;

  // Victim: first invalid way (way 0 first), otherwise the LRU way.
  always_comb begin
    hit_way  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_way  = 1'(w);
        hit_data = way_data[w];
      end
    end
    victim = (WAYS == 1) ? 1'b0 : lru_q[a_set];
    if (!way_valid[0])                      victim = 1'b0;
    else if (WAYS > 1 && !way_valid[WAYS-1]) victim = 1'b1;
  end

  assign lane_data = hit_data >> {A[1:0], 3'b000};

  always_comb begin
    state_d       = state_q;
    fill_set_d    = fill_set_q;
    fill_tag_d    = fill_tag_q;
    fill_way_d    = fill_way_q;
    req_cnt_d     = req_cnt_q;
    rsp_cnt_d     = rsp_cnt_q;
    lru_d         = lru_q;
    way_wr        = '0;
    way_clr       = '0;
    way_set       = '0;
    wr_set        = a_set;
    wr_word       = a_word;
    wr_data       = WD << {A[1:0], 3'b000};
    wr_strb       = lane_strb(dataType, A[1:0]);
    stall         = 1'b0;
    RD            = '0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = {A[ADDR_WIDTH-1:2], 2'b00};
    mem_wdata     = '0;
    mem_wstrb     = '0;
    unique case (state_q)
      IDLE: begin
        if (WE == WE_READ) begin
          if (hit) begin
            case (dataType)
              DT_BYTE: RD = {24'b0, lane_data[7:0]};
              DT_HALF: RD = {16'b0, lane_data[15:0]};
              default: RD = hit_data;
            endcase
            lru_d[a_set] = ~hit_way;
          end else begin
            stall           = 1'b1;
            way_clr[victim] = 1'b1;
            fill_set_d      = a_set;
            fill_tag_d      = a_tag;
            fill_way_d      = victim;
            req_cnt_d       = '0;
            rsp_cnt_d       = '0;
            state_d         = REFILL;
          end
        end else if (WE == WE_WRITE) begin
          mem_req_valid = 1'b1;
          mem_we        = 1'b1;
          mem_wdata     = wr_data;
          mem_wstrb     = wr_strb;
          stall         = !mem_req_ready;
          if (mem_req_ready && hit) begin
            way_wr[hit_way] = 1'b1;
            lru_d[a_set]    = ~hit_way;
          end
        end
      end
      REFILL: begin
        stall    = 1'b1;
        wr_set   = fill_set_q;
        wr_word  = rsp_cnt_q[OFF_W-1:0];
        wr_data  = mem_rdata;
        wr_strb  = 4'b1111;
        mem_addr = {fill_tag_q, fill_set_q, req_cnt_q[OFF_W-1:0], 2'b00};
        if (req_cnt_q < CNT_FULL) begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) req_cnt_d = req_cnt_q + 1'b1;
        end
        if (mem_rvalid) begin
          way_wr[fill_way_q] = 1'b1;
          rsp_cnt_d          = rsp_cnt_q + 1'b1;
          if (rsp_cnt_q == CNT_LAST) begin
            way_set[fill_way_q] = 1'b1;
            lru_d[fill_set_q]   = ~fill_way_q;
            state_d             = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset forces quiet outputs and blocks any array writes, including late responses.
    if (rst) begin
      stall         = 1'b0;
      RD            = '0;
      mem_req_valid = 1'b0;
      mem_we        = 1'b0;
      mem_wstrb     = '0;
      mem_wdata     = '0;
      way_wr        = '0;
      way_clr       = '0;
      way_set       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fill_set_q <= '0;
      fill_tag_q <= '0;
      fill_way_q <= 1'b0;
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_set_q <= fill_set_d;
      fill_tag_q <= fill_tag_d;
      fill_way_q <= fill_way_d;
      req_cnt_q  <= req_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      lru_q      <= lru_d;
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Self-checking bench for dcache_assoc: directed vector table, reset-during-refill
// sequence, then randomized traffic against a block-residency/LRU reference model.
module tb_dcache_assoc;

  localparam logic [1:0] T_IDLE  = 2'b00;
  localparam logic [1:0] T_READ  = 2'b01;
  localparam logic [1:0] T_WRITE = 2'b10;
  localparam logic [1:0] T_WORD  = 2'b00;
  localparam logic [1:0] T_BYTE  = 2'b01;
  localparam logic [1:0] T_HALF  = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  WE = T_IDLE;
  logic [31:0] A = '0;
  logic [1:0]  dataType = T_WORD;
  logic [31:0] WD = '0;
  logic [31:0] RD;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dcache_assoc #(.ADDR_WIDTH(32), .SET_BITS(4), .BLOCK_WORDS(4), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .WE(WE), .A(A), .dataType(dataType), .WD(WD), .RD(RD),
    .stall(stall), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Backing memory: sparse word store, in-order read responses, optional random gaps.
  logic [31:0] bmem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] pend [$];
  int rd_reqs = 0, wr_reqs = 0, rsp_seen = 0;
  bit jitter = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  function automatic logic [31:0] bmem_get(input logic [31:0] a);
    logic [31:0] k = {a[31:2], 2'b00};
    return bmem.exists(k) ? bmem[k] : init_word(k);
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    logic [31:0] k = {a[31:2], 2'b00};
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_rvalid) rsp_seen++;
    if (mem_req_valid && mem_req_ready) begin
      if (mem_we) begin
        w = bmem_get(mem_addr);
        for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        bmem[{mem_addr[31:2], 2'b00}] = w;
        wr_reqs++;
      end else begin
        pend.push_back(mem_addr);
        rd_reqs++;
      end
    end
    if (pend.size() != 0 && (!jitter || $urandom_range(0, 3) != 0)) begin
      mem_rdata  <= bmem_get(pend.pop_front());
      mem_rvalid <= 1'b1;
    end else begin
      mem_rvalid <= 1'b0;
    end
  end

  // Reference cache: per set, resident block addresses in most-recent-first order.
  logic [31:0] mblk [16][2];
  int          mcnt [16];

  function automatic bit model_access(input int s, input logic [31:0] blk, input bit alloc);
    int idx = -1;
    bit was_hit;
    for (int i = 0; i < mcnt[s]; i++) if (mblk[s][i] == blk) idx = i;
    was_hit = (idx >= 0);
    if (!was_hit && !alloc) return 1'b0;
    if (!was_hit) begin
      if (mcnt[s] < 2) mcnt[s]++;
      idx = mcnt[s] - 1;
    end
    for (int i = idx; i > 0; i--) mblk[s][i] = mblk[s][i-1];
    mblk[s][0] = blk;
    return was_hit;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] dt, input logic [1:0] off);
    case (dt)
      T_BYTE:  return 4'b0001 << off;
      T_HALF:  return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] w, input logic [1:0] dt, input logic [1:0] off);
    logic [31:0] s = w >> (8 * off);
    case (dt)
      T_BYTE:  return s & 32'h0000_00FF;
      T_HALF:  return s & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  logic [31:0] r_rd, r_wdata;
  logic [3:0]  r_strb;
  logic        r_first_stall, r_first_rv, r_timeout;
  int          r_cycles, r_reqs, r_wrs;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete core transaction; ready is held low for the first dly cycles.
  task automatic applyStimulus(input logic [1:0] we, input logic [31:0] a, input logic [1:0] dt,
                               input logic [31:0] wd, input int dly);
    int rq0, wr0, cyc;
    @(negedge clk);
    WE = we; A = a; dataType = dt; WD = wd;
    mem_req_ready = (dly == 0);
    rq0 = rd_reqs; wr0 = wr_reqs; cyc = 0;
    #1;
    r_first_stall = stall;
    r_first_rv    = mem_req_valid;
    while (stall && cyc < 300) begin
      @(negedge clk);
      cyc++;
      mem_req_ready = (cyc >= dly);
      #1;
    end
    r_timeout = stall;
    r_cycles  = cyc;
    r_rd      = RD;
    r_strb    = mem_wstrb;
    r_wdata   = mem_wdata;
    @(negedge clk);
    WE = T_IDLE;
    mem_req_ready = 1'b1;
    r_reqs = rd_reqs - rq0;
    r_wrs  = wr_reqs - wr0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; WE = T_IDLE;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 16; s++) mcnt[s] = 0;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [31:0] a;
    logic [1:0]  dt;
    logic [31:0] wd;
    int          dly;
    bit          miss;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, cyc;
    vecs[0]  = '{T_READ,  32'h0001_0000, T_WORD, 32'h0,        0, 1'b1, 32'h4433_2211};
    vecs[1]  = '{T_READ,  32'h0001_000C, T_WORD, 32'h0,        0, 1'b0, 32'h7777_7777};
    vecs[2]  = '{T_READ,  32'h0001_0001, T_BYTE, 32'h0,        0, 1'b0, 32'h0000_0022};
    vecs[3]  = '{T_READ,  32'h0001_0002, T_HALF, 32'h0,        0, 1'b0, 32'h0000_4433};
    vecs[4]  = '{T_WRITE, 32'h0001_0001, T_BYTE, 32'h0000_00AB, 3, 1'b0, 32'h0};
    vecs[5]  = '{T_READ,  32'h0001_0000, T_WORD, 32'h0,        0, 1'b0, 32'h4433_AB11};
    vecs[6]  = '{T_READ,  32'h0002_0000, T_WORD, 32'h0,        0, 1'b1, 32'h2222_0000};
    vecs[7]  = '{T_READ,  32'h0001_0000, T_WORD, 32'h0,        0, 1'b0, 32'h4433_AB11};
    vecs[8]  = '{T_READ,  32'h0003_0000, T_WORD, 32'h0,        0, 1'b1, 32'h3333_0000};
    vecs[9]  = '{T_READ,  32'h0001_0000, T_WORD, 32'h0,        0, 1'b0, 32'h4433_AB11};
    vecs[10] = '{T_READ,  32'h0002_0000, T_WORD, 32'h0,        0, 1'b1, 32'h2222_0000};
    vecs[11] = '{T_WRITE, 32'h0005_0000, T_WORD, 32'hCAFE_F00D, 0, 1'b0, 32'h0};
    vecs[12] = '{T_READ,  32'h0005_0000, T_WORD, 32'h0,        0, 1'b1, 32'hCAFE_F00D};

    bmem[32'h0001_0000] = 32'h4433_2211;
    bmem[32'h0001_0004] = 32'h5555_5555;
    bmem[32'h0001_0008] = 32'h6666_6666;
    bmem[32'h0001_000C] = 32'h7777_7777;
    bmem[32'h0002_0000] = 32'h2222_0000;
    bmem[32'h0003_0000] = 32'h3333_0000;

    // Reset with a pending-looking write on the inputs: outputs must stay quiet.
    rst = 1'b1; WE = T_WRITE; A = 32'h0001_0001; dataType = T_BYTE; WD = 32'hFF;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_req_valid", mem_req_valid, 0);
    checkOutput("reset_rd", RD, 0);
    checkOutput("reset_wstrb", mem_wstrb, 0);
    @(negedge clk);
    rst = 1'b0; WE = T_IDLE;
    #1;
    checkOutput("idle_rd", RD, 0);
    checkOutput("idle_stall", stall, 0);
    checkOutput("reset_no_write", wr_reqs, 0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].we, vecs[i].a, vecs[i].dt, vecs[i].wd, vecs[i].dly);
      checkOutput($sformatf("v%0d_timeout", i), r_timeout, 0);
      if (vecs[i].we == T_READ) begin
        checkOutput($sformatf("v%0d_miss", i), r_first_stall, vecs[i].miss);
        checkOutput($sformatf("v%0d_rd", i), r_rd, vecs[i].rd);
        checkOutput($sformatf("v%0d_reqs", i), r_reqs, vecs[i].miss ? 4 : 0);
        checkOutput($sformatf("v%0d_first_req_valid", i), r_first_rv, 0);
      end else begin
        checkOutput($sformatf("v%0d_first_stall", i), r_first_stall, vecs[i].dly != 0);
        checkOutput($sformatf("v%0d_stall_cycles", i), r_cycles, vecs[i].dly);
        checkOutput($sformatf("v%0d_writes", i), r_wrs, 1);
        checkOutput($sformatf("v%0d_no_refill", i), r_reqs, 0);
        checkOutput($sformatf("v%0d_wstrb", i), r_strb, exp_strb(vecs[i].dt, vecs[i].a[1:0]));
        checkOutput($sformatf("v%0d_wdata", i), r_wdata, vecs[i].wd << (8 * vecs[i].a[1:0]));
      end
    end

    // Reset after two of four refill responses have been consumed.
    doReset();
    @(negedge clk);
    WE = T_READ; A = 32'h0001_0000; dataType = T_WORD;
    base = rsp_seen; cyc = 0;
    while (rsp_seen - base < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("midfill_two_rsps", rsp_seen - base, 2);
    checkOutput("midfill_stall", stall, 1);
    rst = 1'b1; WE = T_WRITE; A = 32'h0001_0001; dataType = T_BYTE; WD = 32'hFF;
    #1;
    checkOutput("midfill_rst_stall", stall, 0);
    checkOutput("midfill_rst_req_valid", mem_req_valid, 0);
    @(negedge clk);
    rst = 1'b0; WE = T_IDLE;
    #1;
    checkOutput("post_rst_stall", stall, 0);
    checkOutput("post_rst_req_valid", mem_req_valid, 0);
    cyc = 0;
    while ((pend.size() != 0 || mem_rvalid) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    checkOutput("late_rsp_stall", stall, 0);
    checkOutput("late_rsp_rd", RD, 0);
    for (int s = 0; s < 16; s++) mcnt[s] = 0;
    applyStimulus(T_READ, 32'h0001_0000, T_WORD, 32'h0, 0);
    checkOutput("after_abort_miss", r_first_stall, 1);
    checkOutput("after_abort_rd", r_rd, 32'h4433_AB11);
    checkOutput("after_abort_reqs", r_reqs, 4);

    // Randomized phase: three tags contend for two ways in each of two sets.
    doReset();
    foreach (bmem[k]) ref_mem[k] = bmem[k];
    jitter = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, data, blk, w;
      logic [1:0]  dt, off;
      logic [3:0]  strb;
      bit          isw, hit;
      int          s, dly;
      dt  = 2'($urandom_range(0, 3));
      off = 2'($urandom_range(0, 3));
      if (dt == T_HALF) off[0] = 1'b0;
      else if (dt != T_BYTE) off = 2'b00;
      s    = $urandom_range(0, 1);
      a    = ($urandom_range(1, 3) << 16) | (s << 4) | ($urandom_range(0, 3) << 2) | off;
      isw  = ($urandom_range(0, 9) < 4);
      dly  = $urandom_range(0, 2);
      data = $urandom();
      blk  = a & ~32'hF;
      if (isw) begin
        void'(model_access(s, blk, 1'b0));
        strb = exp_strb(dt, off);
        w = ref_get(a);
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = 8'((data << (8 * off)) >> (8 * b));
        ref_mem[{a[31:2], 2'b00}] = w;
        applyStimulus(T_WRITE, a, dt, data, dly);
        checkOutput($sformatf("r%0d_timeout", i), r_timeout, 0);
        checkOutput($sformatf("r%0d_wr_stall_cycles", i), r_cycles, dly);
        checkOutput($sformatf("r%0d_wstrb", i), r_strb, strb);
        checkOutput($sformatf("r%0d_wdata", i), r_wdata, data << (8 * off));
        checkOutput($sformatf("r%0d_writes", i), r_wrs, 1);
      end else begin
        hit = model_access(s, blk, 1'b1);
        applyStimulus(T_READ, a, dt, data, dly);
        checkOutput($sformatf("r%0d_timeout", i), r_timeout, 0);
        checkOutput($sformatf("r%0d_miss", i), r_first_stall, !hit);
        checkOutput($sformatf("r%0d_rd", i), r_rd, exp_rd(ref_get(a), dt, off));
        checkOutput($sformatf("r%0d_reqs", i), r_reqs, hit ? 0 : 4);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised set-associative data cache with multi-word blocks, placed between the RISC-V core's load/store unit and backing data memory. A synchronous refill FSM replaces the combinational miss-fill of the previous cache generation. The core-side contract is unchanged (`WE`, `A`, `dataType`, `WD`, `RD`), plus a `stall` output. The memory side is a valid/ready request port with in-order read responses; write policy is write-through, no-write-allocate, with byte-lane merging.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `SET_BITS`, 4: index bits; 2**SET_BITS sets.
- `BLOCK_WORDS`, 4: 32-bit words per block; power of two, ≥2.
- `WAYS`, 2: associativity; legal values 1 or 2.
- Tag width = ADDR_WIDTH − SET_BITS − log2(BLOCK_WORDS) − 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `WE`  in  2  01 read, 10 write, 00/11 idle.
- `A`  in  ADDR_WIDTH  byte address.
- `dataType`  in  2  00 word, 01 byte, 10 halfword; 11 is treated as word.
- `WD`  in  32  store data, right-aligned.
- `RD`  out  32  load data, zero-extended.
- `stall`  out  1  core must hold all inputs stable while high.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts request this cycle.
- `mem_we`  out  1  1 = write request.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address.
- `mem_wdata`  out  32  store data, byte-lane aligned.
- `mem_wstrb`  out  4  byte-lane enables.
- `mem_rvalid`  in  1  read response valid; responses return in request order.
- `mem_rdata`  in  32  read response word.

## Operation
- Address split: A[1:0] selects the byte, then the block offset, then the index, then the tag. Halfword accesses use A[1]; word accesses ignore A[1:0]. Misaligned accesses are undefined.
- State per set: one valid bit and one tag per way, plus one LRU bit when WAYS=2 (points to the least-recently-used way).
- FSM states: IDLE, REFILL.
- IDLE, read hit:
  - RD is valid combinationally, `stall`=0.
  - LRU is updated at the edge.
- IDLE, read miss:
  - `stall`=1.
  - Victim way = first invalid way (way 0 first), otherwise the LRU way.
  - At the edge: clear the victim's valid bit, latch the block base and victim way, move to REFILL.
- REFILL:
  - Issue BLOCK_WORDS read requests to base, base+4, and so on. `req_cnt` advances on each accepted request.
  - Each `mem_rvalid` writes word `rsp_cnt` into the victim way; `rsp_cnt` then increments.
  - On the last response: set valid, write the tag, point LRU at the other way, move to IDLE.
  - `stall`=1 throughout REFILL.
  - `mem_rvalid` is ignored in IDLE.
- IDLE, write:
  - Drive `mem_req_valid`=1, `mem_we`=1. `mem_wstrb` = 1111 for word, 0011<<A[1:0] for halfword, 0001<<A[1:0] for byte. `WD` is shifted to the matching lane.
  - `stall` = !`mem_req_ready`.
  - On acceptance: on a hit, merge only the strobed bytes into the line and update LRU. On a miss, the cache is unchanged.
- RD byte/halfword extraction uses A[1:0]; upper bits are zero. RD=0 whenever WE≠01 or `stall`=1.
- Reset: FSM to IDLE, all valid and LRU bits cleared, counters to 0. Data and tag arrays are not reset.
- Output reset values: `stall`=0, `mem_req_valid`=0, RD=0, `mem_wstrb`=0.
- Reset mid-refill: the refill is abandoned and late responses are dropped. Backing memory must tolerate this.

## Timing
- Read hit: 0-cycle latency, no stall.
- Read miss: `stall` high from the miss cycle through the cycle of the last `mem_rvalid`. Data is presented with `stall`=0 the following cycle (IDLE hit). Minimum 1+BLOCK_WORDS cycles with zero-wait memory.
- Write: one cycle plus the number of cycles `mem_req_ready` is low.
- Requests may overlap responses. With BLOCK_WORDS requests outstanding, `mem_req_valid` deasserts.

## Structure
- `dcache_pkg`:
  - WE encodings: WE_IDLE, WE_READ, WE_WRITE.
  - dataType encodings: DT_WORD, DT_BYTE, DT_HALF.
  - `state_t` enum (IDLE, REFILL).
  - Strobe/lane helper function.
- Sub-module `dcache_way`, instantiated WAYS times: one tag array, one valid array, one data array.
  - Reads are combinational.
  - Writes are word-write with byte strobes.
  - Provides valid-clear and set-valid ports.

## Test plan
- Reset, preload 0x10000..0x1000F = 0x44332211, 0x55555555, 0x66666666, 0x77777777. Read word at 0x10000: 4 requests at 0x10000/4/8/C, then RD=0x44332211 with `stall`=0. A subsequent read at 0x1000C hits in the same cycle with RD=0x77777777 and no `mem_req_valid`.
- After the fill: byte read at 0x10001 → RD=0x00000022; halfword read at 0x10002 → RD=0x00004433.
- Byte write WD=0xAB at 0x10001 with `mem_req_ready` low for 3 cycles: `stall` high for 3 cycles, `mem_wstrb`=0010, `mem_wdata`[15:8]=0xAB. Then a word read at 0x10000 hits with RD=0x4433AB11.
- WAYS=2: read 0x10000, 0x20000, 0x10000, then 0x30000. The last read evicts the 0x20000 line; a read at 0x10000 hits, and a read at 0x20000 misses.
- Write miss at 0x50000: one memory write with no refill. The next read at 0x50000 misses and refills.
- Assert `rst` after 2 of 4 refill responses: `stall`=0 the next cycle, later `mem_rvalid` pulses are ignored, and a read at 0x10000 misses.
